// File: rtl/ldl_align_hunt.sv
// ldl_align_hunt
// Word-alignment hunter for a marker-framed stream. At each marker position
// the incoming word is rotated right by the current step and compared with
// the alignment pattern. Misses while hunting advance the step by one.
// LOCK_CNT consecutive hits declare lock, and LOSS_CNT consecutive misses
// while locked drop lock and restart the hunt. The step and direction
// outputs drive an external ring rotator.
module ldl_align_hunt #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] PATTERN = 'hB8,
    parameter int              LOCK_CNT = 3,
    parameter int              LOSS_CNT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    input  logic                     in_mark,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     resync,
    output logic [$clog2(WIDTH)-1:0] step,
    output logic                     dir,
    output logic                     locked,
    output logic                     slip,
    output logic                     lock_lost
);

    localparam int SW = $clog2(WIDTH);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);

    localparam logic [SW-1:0] STEP_MAX  = SW'(WIDTH - 1);
    localparam logic [SW:0]   WIDTH_L   = (SW + 1)'(WIDTH);
    localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_CNT);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [GW-1:0] GOOD_ONE  = GW'(1);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT - 1);
    localparam logic [MW-1:0] MISS_ONE  = MW'(1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [GW-1:0]   good_q, good_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic            locked_q, locked_d;
    logic            slip_q, slip_d;
    logic            lost_q, lost_d;

    logic            check;
    logic            match;
    logic [WIDTH-1:0] rot;
    logic [SW-1:0]   step_adv;

    // Rotate the word right by the registered step and test for the marker;
    // a shift by WIDTH yields zero, so step 0 passes the word through.
    always_comb begin
        rot      = (in_data >> step_q) | (in_data << (WIDTH_L - {1'b0, step_q}));
        match    = (rot == PATTERN);
        check    = in_vld & in_mark;
        step_adv = (step_q == STEP_MAX) ? '0 : step_q + 1'b1;
    end

    // State register: FSM state, step, saturating counters and output pulses.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HUNT;
            step_q   <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            slip_q   <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            slip_q   <= slip_d;
            lost_q   <= lost_d;
        end
    end

    // Next-state logic: resync overrides any check in the same cycle.
    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_d = state_q;
        step_d  = step_q;
        good_d  = good_q;
        miss_d  = miss_q;
        slip_d  = 1'b0;
        lost_d  = 1'b0;

        if (resync) begin
            state_d = ST_HUNT;
            good_d  = '0;
            miss_d  = '0;
            lost_d  = (state_q == ST_LOCK);
        end else if (check) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (match) begin
                        good_d = (LOCK_CNT == 1) ? GOOD_MAX : GOOD_ONE;
                        miss_d = '0;
                        state_d = (LOCK_CNT == 1) ? ST_LOCK : ST_VERIFY;
                    end else begin
                        step_d = step_adv;
                        slip_d = 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (match) begin
                        if (good_q >= GOOD_LAST) begin
                            good_d  = GOOD_MAX;
                            miss_d  = '0;
                            state_d = ST_LOCK;
                        end else begin
                            good_d = good_q + GOOD_ONE;
                        end
                    end else begin
                        state_d = ST_HUNT;
                        good_d  = '0;
                        step_d  = step_adv;
                        slip_d  = 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (match) begin
                        miss_d = '0;
                    end else if (miss_q >= MISS_LAST) begin
                        state_d = ST_HUNT;
                        good_d  = '0;
                        miss_d  = '0;
                        step_d  = step_adv;
                        slip_d  = 1'b1;
                        lost_d  = 1'b1;
                    end else begin
                        miss_d = miss_q + MISS_ONE;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    good_d  = '0;
                    miss_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCK);
    end

    // Output logic: all outputs come straight from registers; direction is fixed right.
    always_comb begin
        step      = step_q;
        dir       = 1'b0;
        locked    = locked_q;
        slip      = slip_q;
        lock_lost = lost_q;
    end

endmodule

// File: tb/tb_ldl_align_hunt.sv
// Testbench for ldl_align_hunt (WIDTH=8, PATTERN=8'hB8, LOCK_CNT=3, LOSS_CNT=2).
// The driver applies one input set per cycle and queues the hand-computed
// outputs expected after the following rising edge; a monitor pops and
// compares them shortly after each rising edge.
module tb_ldl_align_hunt;

    logic       clk;
    logic       rst_n;
    logic       in_vld;
    logic       in_mark;
    logic [7:0] in_data;
    logic       resync;
    logic [2:0] step;
    logic       dir;
    logic       locked;
    logic       slip;
    logic       lock_lost;

    typedef struct {
        logic [2:0] step;
        logic       locked;
        logic       slip;
        logic       lost;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ldl_align_hunt #(
        .WIDTH    (8),
        .PATTERN  (8'hB8),
        .LOCK_CNT (3),
        .LOSS_CNT (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .in_mark   (in_mark),
        .in_data   (in_data),
        .resync    (resync),
        .step      (step),
        .dir       (dir),
        .locked    (locked),
        .slip      (slip),
        .lock_lost (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic cyc(input logic v, input logic m, input logic [7:0] d, input logic rs,
                       input logic [2:0] es, input logic el, input logic esl,
                       input logic ell, input string tag);
        exp_t e;
        @(negedge clk);
        in_vld  = v;
        in_mark = m;
        in_data = d;
        resync  = rs;
        e.step   = es;
        e.locked = el;
        e.slip   = esl;
        e.lost   = ell;
        e.tag    = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_vld  = 1'b0;
        in_mark = 1'b0;
        in_data = 8'h00;
        resync  = 1'b0;
    endtask

    // 8'hC5 rotated right by 3 equals 8'hB8: three slips, then three hits to lock.
    task automatic hunt_and_lock(input string tag);
        cyc(1, 1, 8'hC5, 0, 3'd1, 0, 1, 0, {tag, "_chk1"});
        cyc(1, 1, 8'hC5, 0, 3'd2, 0, 1, 0, {tag, "_chk2"});
        cyc(1, 1, 8'hC5, 0, 3'd3, 0, 1, 0, {tag, "_chk3"});
        cyc(1, 1, 8'hC5, 0, 3'd3, 0, 0, 0, {tag, "_chk4"});
        cyc(1, 1, 8'hC5, 0, 3'd3, 0, 0, 0, {tag, "_chk5"});
        cyc(1, 1, 8'hC5, 0, 3'd3, 1, 0, 0, {tag, "_chk6"});
    endtask

    // Monitor: compare queued expectations against the DUT just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".step"},      {5'd0, step},      {5'd0, e.step});
                check({e.tag, ".locked"},    {7'd0, locked},    {7'd0, e.locked});
                check({e.tag, ".slip"},      {7'd0, slip},      {7'd0, e.slip});
                check({e.tag, ".lock_lost"}, {7'd0, lock_lost}, {7'd0, e.lost});
                check({e.tag, ".dir"},       {7'd0, dir},       8'd0);
            end
        end
    end

    // Watchdog: the run must always terminate.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_mark = 1'b0;
        in_data = 8'h00;
        resync  = 1'b0;

        #12;
        check("reset.step",      {5'd0, step},      8'd0);
        check("reset.locked",    {7'd0, locked},    8'd0);
        check("reset.slip",      {7'd0, slip},      8'd0);
        check("reset.lock_lost", {7'd0, lock_lost}, 8'd0);
        check("reset.dir",       {7'd0, dir},       8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hunt and lock from step 0.
        hunt_and_lock("hunt");

        // Single miss is tolerated and cleared by a hit; two misses drop lock.
        cyc(1, 1, 8'h00, 0, 3'd3, 1, 0, 0, "loss_miss1");
        cyc(1, 1, 8'hC5, 0, 3'd3, 1, 0, 0, "loss_hit");
        cyc(1, 1, 8'h00, 0, 3'd3, 1, 0, 0, "loss_miss1b");
        cyc(1, 1, 8'h00, 0, 3'd4, 0, 1, 1, "loss_miss2");

        // Gaps: non-marker and invalid cycles leave everything alone.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) cyc(1, 0, 8'h00, 0, 3'd4, 0, 0, 0, $sformatf("gap_nomark%0d", i));
            else            cyc(0, 1, 8'h00, 0, 3'd4, 0, 0, 0, $sformatf("gap_novld%0d", i));
        end

        // Wrap: mismatches walk the step 4 -> 5 -> 6 -> 7 -> 0.
        cyc(1, 1, 8'h00, 0, 3'd5, 0, 1, 0, "wrap_5");
        cyc(1, 1, 8'h00, 0, 3'd6, 0, 1, 0, "wrap_6");
        cyc(1, 1, 8'h00, 0, 3'd7, 0, 1, 0, "wrap_7");
        cyc(1, 1, 8'h00, 0, 3'd0, 0, 1, 0, "wrap_0");
        cyc(0, 0, 8'h00, 0, 3'd0, 0, 0, 0, "wrap_slip_end");

        // Priority: resync wins over a matching check in VERIFY.
        cyc(1, 1, 8'hB8, 0, 3'd0, 0, 0, 0, "prio_v1");
        cyc(1, 1, 8'hB8, 0, 3'd0, 0, 0, 0, "prio_v2");
        cyc(1, 1, 8'hB8, 1, 3'd0, 0, 0, 0, "prio_resync");
        cyc(1, 1, 8'hB8, 0, 3'd0, 0, 0, 0, "relock_1");
        cyc(1, 1, 8'hB8, 0, 3'd0, 0, 0, 0, "relock_2");
        cyc(1, 1, 8'hB8, 0, 3'd0, 1, 0, 0, "relock_3");

        // Resync from LOCK pulses lock_lost only.
        cyc(0, 0, 8'h00, 1, 3'd0, 0, 0, 1, "resync_lock");
        cyc(0, 0, 8'h00, 0, 3'd0, 0, 0, 0, "resync_lock_end");

        // Resync in HUNT blocks a mismatching check; the next check slips.
        cyc(1, 1, 8'h00, 1, 3'd0, 0, 0, 0, "resync_hunt");
        cyc(1, 1, 8'h00, 0, 3'd1, 0, 1, 0, "hunt_after_resync");

        // Reach VERIFY at step 3, then reset asynchronously between edges.
        cyc(1, 1, 8'hC5, 0, 3'd2, 0, 1, 0, "pre_rst_1");
        cyc(1, 1, 8'hC5, 0, 3'd3, 0, 1, 0, "pre_rst_2");
        cyc(1, 1, 8'hC5, 0, 3'd3, 0, 0, 0, "pre_rst_v1");
        cyc(1, 1, 8'hC5, 0, 3'd3, 0, 0, 0, "pre_rst_v2");
        @(posedge clk);
        #3;
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_mark = 1'b0;
        #1;
        check("midrst.step",      {5'd0, step},      8'd0);
        check("midrst.locked",    {7'd0, locked},    8'd0);
        check("midrst.slip",      {7'd0, slip},      8'd0);
        check("midrst.lock_lost", {7'd0, lock_lost}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        hunt_and_lock("rehunt");
        idle();

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ldl_align_hunt.md
LDL_ALIGN_HUNT -- requirements
Module: LDL_align_hunt

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: word width in bits; legal range >= 2, need not be a power of two.
- REQ-002 SHALL have parameter PATTERN, default 'hB8: alignment marker; the low WIDTH bits are used.
- REQ-003 SHALL have parameter LOCK_CNT, default 3: consecutive marker matches required to declare lock; legal range >= 1.
- REQ-004 SHALL have parameter LOSS_CNT, default 2: consecutive marker misses that drop lock; legal range >= 1.
- REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-007 SHALL have port in_vld, input, 1 bit: in_data is valid this cycle.
- REQ-008 SHALL have port in_mark, input, 1 bit: the current valid word is a marker position.
- REQ-009 SHALL have port in_data, input, WIDTH bits: unaligned word.
- REQ-010 SHALL have port resync, input, 1 bit: forces a return to HUNT.
- REQ-011 SHALL have port step, output, $clog2(WIDTH) bits: rotate amount for the downstream ring rotator.
- REQ-012 SHALL have port dir, output, 1 bit: rotate direction; tied to 0 (right).
- REQ-013 SHALL have port locked, output, 1 bit: alignment is locked.
- REQ-014 SHALL have port slip, output, 1 bit: one-cycle pulse when step advances.
- REQ-015 SHALL have port lock_lost, output, 1 bit: one-cycle pulse on a LOCK to HUNT transition.

Function
- REQ-016 A check event SHALL occur only in a cycle where in_vld=1 and in_mark=1; all other cycles leave the state unchanged.
- REQ-017 The match condition SHALL be: rotate-right(in_data, step) == PATTERN[WIDTH-1:0], evaluated combinationally against the current registered step.
- REQ-018 The FSM SHALL have three states: HUNT, VERIFY and LOCK. good_cnt and miss_cnt SHALL be saturating counters.
- REQ-019 In HUNT, a check with match SHALL set good_cnt=1 and move to VERIFY, or to LOCK directly if LOCK_CNT=1.
- REQ-020 In HUNT, a check with mismatch SHALL advance step and assert slip.
- REQ-021 In VERIFY, a check with match SHALL increment good_cnt; reaching LOCK_CNT SHALL move to LOCK with miss_cnt=0.
- REQ-022 In VERIFY, a check with mismatch SHALL move to HUNT, advance step and assert slip.
- REQ-023 In LOCK, a check with match SHALL clear miss_cnt.
- REQ-024 In LOCK, a check with mismatch SHALL increment miss_cnt; reaching LOSS_CNT SHALL move to HUNT, advance step, and pulse both slip and lock_lost.
- REQ-025 Advancing step SHALL mean step <= (step == WIDTH-1) ? 0 : step+1; step SHALL wrap to 0 and never exceed WIDTH-1.
- REQ-026 step SHALL update in the cycle after the check; the next check SHALL use the new value. Latency from check to updated step/locked SHALL be 1 clock.
- REQ-027 locked SHALL be a registered output, 1 exactly when the state is LOCK.
- REQ-028 resync=1 SHALL force HUNT, clear both counters and leave step unchanged; it SHALL take priority over a simultaneous check.
- REQ-029 A resync issued from LOCK SHALL pulse lock_lost and SHALL NOT pulse slip.
- REQ-030 For rotationally symmetric patterns, the first matching step reached by hunting SHALL win; no ambiguity detection is required.
- REQ-031 If no step ever matches, step SHALL keep cycling 0..WIDTH-1 indefinitely, with one slip per check.

Reset
- REQ-032 When rst_n=0 (asynchronous), the block SHALL enter HUNT with step=0, dir=0, locked=0, slip=0, lock_lost=0, good_cnt=0 and miss_cnt=0.
- REQ-033 Reset SHALL abort any state mid-operation; the first check after rst_n deasserts SHALL use step=0.

Verification (WIDTH=8, PATTERN=8'hB8, LOCK_CNT=3, LOSS_CNT=2)
- REQ-034 Hunt and lock: marker words 8'hC5 every cycle -> slips on checks 1-3 and step=3 after the 3rd check; matches on checks 4-6; locked=1 the cycle after check 6.
- REQ-035 Loss: from lock at step=3, feed one 8'h00 marker then 8'hC5 -> stays locked. Then feed two 8'h00 markers -> locked=0, lock_lost and slip pulse once, step=4.
- REQ-036 Wrap: step=7 in HUNT, then a mismatching check -> step=0, slip=1 for one cycle.
- REQ-037 Gaps: in_vld=1 with in_mark=0, or in_vld=0, over 10 cycles -> no state, step or counter change.
- REQ-038 Priority: resync=1 together with a matching check in VERIFY -> HUNT, good_cnt=0, step unchanged, no slip.
- REQ-039 Reset mid-VERIFY: rst_n pulsed low asynchronously between clock edges -> outputs immediately at reset values (step=0, locked=0); re-hunt completes as in REQ-034.
